// File: rtl/shift_chain_sched.sv
// Round-robin owner of a shared D-stage serial shift chain: grants one of two
// requesters, shifts its word out LSB-first, and reassembles the returning bits.
module shift_chain_sched #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         c,
  input  logic         rstn,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] word0,
  input  logic [W-1:0] word1,
  input  logic         stall,
  input  logic         sout,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sen,
  output logic         sdin,
  output logic         busy,
  output logic         dvalid,
  output logic [W-1:0] dout,
  output logic         downer
);

  localparam int CW = $clog2(W + D + 1);
  localparam logic [CW-1:0] W_C    = CW'(W);
  localparam logic [CW-1:0] LAST_C = CW'(W + D - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  pl_q;
  logic [W-1:0]  cap_q;
  logic [W-1:0]  cap_d;
  logic [W-1:0]  dout_q;
  logic          last_q;
  logic          owner_q;
  logic          downer_q;
  logic          gnt0_q;
  logic          gnt1_q;
  logic          win_d;

  // On a tie the requester not served last wins; otherwise the sole requester.
  assign win_d = (req0 && req1) ? ~last_q : req1;

  // Bit k of the word returns from the chain end D shifts after it entered.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_cap
      assign cap_d[gi] = (cnt_q == CW'(gi + D)) ? sout : cap_q[gi];
    end
  endgenerate

  always_ff @(posedge c) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pl_q     <= '0;
      cap_q    <= '0;
      dout_q   <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      downer_q <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            pl_q    <= win_d ? word1 : word0;
            owner_q <= win_d;
            last_q  <= win_d;
            cnt_q   <= '0;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!stall) begin
            pl_q  <= pl_q >> 1;
            cap_q <= cap_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_C) begin
              dout_q   <= cap_d;
              downer_q <= owner_q;
              state_q  <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign sen    = (state_q == SHIFT) && !stall;
  assign sdin   = (state_q == SHIFT) && (cnt_q < W_C) && pl_q[0];
  assign busy   = (state_q != IDLE);
  assign dvalid = (state_q == DONE);
  assign dout   = dout_q;
  assign downer = downer_q;

endmodule

// File: doc/shift_chain_sched.md
# shift_chain_sched

Round-robin scheduler that shares one external D-stage serial shift chain (a clock-enabled flop chain, one bit in, last stage out) between two requesters. Grants the chain to one requester, drives the word into the chain LSB-first, and flushes it through. Collects the bits returning from the chain end back into a parallel word, giving a loop-through check of the chain. Sits between the requester logic and the shift-chain datapath, and is the only driver of the chain's data input and shift enable.

## Interface
- W, 8, word width in bits (≥1)
- D, 3, chain depth in stages (≥1); must equal the attached chain's depth
- c  input  1  clock; all state updates on posedge
- rstn  input  1  synchronous active-low reset
- req0, req1  input  1 each  level request; held until the matching gnt pulse is seen
- word0, word1  input  W each  payload; sampled only in the cycle the request is accepted
- stall  input  1  freezes shifting while high
- sout  input  1  serial bit from the last chain stage (registered in the chain)
- gnt0, gnt1  output  1 each  one-cycle acceptance pulse
- sen  output  1  chain shift enable
- sdin  output  1  serial bit into the first chain stage
- busy  output  1  high in SHIFT and DONE
- dvalid  output  1  one-cycle pulse: dout and downer are valid
- dout  output  W  word reassembled from sout
- downer  output  1  requester index (0/1) of the word in dout

## Operation
- States: IDLE, SHIFT, DONE. Shift counter cnt has width clog2(W+D+1). Internal registers: payload shift register pl[W-1:0], capture register, and last-served flag `last`.
- IDLE: if no request, stay. If any request, select the winner:
  - If only one requester is active, it wins.
  - If both are active, the winner is the requester that is not `last`. After reset, `last`=1, so req0 wins the first tie.
  - On the accepting edge: pl←winner's word, owner←winner, `last`←winner, cnt←0, gnt of the winner←1 for the next cycle only, state→SHIFT.
- SHIFT:
  - sen = !stall (combinational).
  - sdin = pl[0] while cnt<W, else 0, so D flush zeros follow the word.
  - On each edge with sen=1: pl shifts right by one.
  - On each edge with sen=1 and cnt≥D: capture bit [cnt−D] ← sout.
  - On each edge with sen=1: cnt←cnt+1.
  - After the edge with sen=1 and cnt=W+D−1, state→DONE.
  - With stall=1, nothing changes.
- DONE:
  - sen=0.
  - dvalid=1; dout=capture register; downer=owner.
  - Next edge: state→IDLE.
- dout and downer hold their values after DONE until the next DONE. dvalid is 0 outside DONE.
- Requests raised during SHIFT or DONE wait. They are arbitrated on the first IDLE cycle.
- A requester must drop its req by the time the block returns to IDLE, otherwise it is served again.
- Chain contract: with a correct D-stage chain, dout equals the accepted word exactly.

## Timing
- Reset (rstn=0 at an edge), from any state including mid-SHIFT:
  - state=IDLE, cnt=0, `last`=1.
  - gnt0=gnt1=0, sen=0, sdin=0, busy=0, dvalid=0, dout=0, downer=0.
  - The partial transfer is discarded with no dvalid.
  - The external chain contents are not cleared.
- Request accepted at edge e0:
  - gnt and busy are high in cycle e0+1.
  - Shifting occupies W+D unstalled cycles.
  - dvalid is high in cycle e0+W+D+1.
  - IDLE is reached in cycle e0+W+D+2.
- Back-to-back throughput: one word per W+D+2 cycles.
- Each stall cycle during SHIFT delays dvalid by exactly one cycle. Stall is ignored in IDLE and DONE.
- Simultaneous req0 and req1 in IDLE: exactly one gnt fires. The other requester is served next if it stays asserted, which alternates service.
- sen and sdin are combinational from registered state, valid in the same cycle.

## Test plan
- W=8, D=3, req0=1 with word0=0xA5 accepted at edge 0 → gnt0 high in cycle 1; sen high for cycles 1–11; sdin = 1,0,1,0,0,1,0,1,0,0,0; dvalid in cycle 12 with dout=0xA5, downer=0; busy low in cycle 13.
- req0 and req1 both high from reset, word0=0x3C, word1=0xC3 → 0x3C delivered with downer=0, then 0xC3 delivered with downer=1, dvalid pulses 13 cycles apart.
- req1 held continuously, re-asserting after each gnt, while req0 also pending → grants alternate 0,1,0,1. Neither requester is granted twice in a row while the other is waiting.
- Stall high for 2 cycles at cnt=5 with word0=0xFF → sen low for those 2 cycles; dvalid in cycle 14; dout=0xFF.
- rstn low for one edge at cnt=6, then req1 with word1=0x81 → no dvalid from the aborted word; all outputs zero after reset; req1 is served with dout=0x81, downer=1.
- Chain model with stuck-at-0 on its last stage, word0=0xFF → dout=0x00. This confirms dout comes from sout and not from the payload register.
